// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB3 word-addressed slave memory with programmable wait states
//
// Purpose: endpoint memory for the bridge's APB master. Decodes a 4 KiB window
// at BASE_ADDR, inserts WAIT_CYCLES wait states per access, flags bad
// addresses with pslverr and records master protocol violations in a sticky flag.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   psel       slave select
//   penable    access phase indicator
//   pwrite     1 = write, 0 = read
//   paddr      byte address
//   pwdata     write data
//   prdata     read data, 0 unless a read completes without error
//   pready     transfer-complete strobe
//   pslverr    error response, valid with pready
//   proto_err  sticky protocol-violation flag, cleared only by reset

module apb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0001_F000,
  parameter int                    DEPTH       = 64,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  proto_err
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]            WAIT_LIM  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4096);
  localparam logic [10:0]           DEPTH_LIM = 11'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q;
  logic [3:0]              wait_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic                    err_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    proto_err_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Address decode, evaluated on the live bus and latched at setup.
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    dec_err_d;
  logic [IDX_W-1:0]        idx_d;

  always_comb begin
    offset    = paddr - BASE_ADDR;
    idx_d     = offset[IDX_W+1:2];
    dec_err_d = (paddr < BASE_ADDR)
             || (offset >= WIN_BYTES)
             || (paddr[1:0] != 2'b00)
             || ({1'b0, offset[11:2]} >= DEPTH_LIM);
  end

  // Completion cycle: counter has reached the limit and the master still selects us.
  // Gating on psel means a dropped select neither completes nor writes.
  logic done;
  assign done = (state_q == ACCESS) && (wait_cnt_q == WAIT_LIM) && psel;

  assign pready    = done;
  assign pslverr   = done && err_q;
  assign prdata    = (done && !write_q && !err_q) ? mem_q[idx_q] : '0;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            addr_q     <= paddr;
            write_q    <= pwrite;
            err_q      <= dec_err_d;
            idx_q      <= idx_d;
            wait_cnt_q <= '0;
            state_q    <= ACCESS;
          end else if (psel && penable) begin
            // Access phase without a setup cycle: ignored apart from the flag.
            proto_err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b1;
          end else begin
            // The transfer still runs to completion after a mismatch; only the flag records it.
            if (!penable || (paddr != addr_q) || (pwrite != write_q)) proto_err_q <= 1'b1;
            if (wait_cnt_q == WAIT_LIM) begin
              state_q <= IDLE;
              if (write_q && !err_q) mem_q[idx_q] <= pwdata;
            end else begin
              wait_cnt_q <= wait_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench for apb_slave_mem on two psel lines

module tb_apb_slave_mem;

  localparam int W0 = 2;
  localparam int W1 = 0;
  localparam logic [31:0] BASE0 = 32'h0001_F000;
  localparam logic [31:0] BASE1 = 32'h0002_F000;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1, proto_err0, proto_err1;

  always #5 clk = ~clk;

  apb_slave_mem #(.BASE_ADDR(BASE0), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .proto_err(proto_err0)
  );

  apb_slave_mem #(.BASE_ADDR(BASE1), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .proto_err(proto_err1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model0 [64];
  logic [31:0] model1 [64];
  int          rdy_cnt0 = 0;

  always @(posedge clk) if (pready0) rdy_cnt0++;

  function automatic logic rdy(input int b);
    return b ? pready1 : pready0;
  endfunction
  function automatic logic [31:0] rdat(input int b);
    return b ? prdata1 : prdata0;
  endfunction
  function automatic logic serr(input int b);
    return b ? pslverr1 : pslverr0;
  endfunction

  function automatic bit dec_err(input int b, input logic [31:0] a);
    logic [31:0] base, off;
    base = b ? BASE1 : BASE0;
    if (a < base) return 1'b1;
    off = a - base;
    if (off >= 32'd4096) return 1'b1;
    if (a[1:0] != 2'b00) return 1'b1;
    if ((off >> 2) >= 32'd64) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_psel(input int b, input logic v);
    if (b) psel1 = v; else psel0 = v;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 64; i++) begin
      model0[i] = '0;
      model1[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_models();
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge. hold keeps psel high for a back-to-back setup.
  task automatic apb_xfer(input int b, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
    exp_t        e;
    int          cyc;
    bit          seen, err;
    logic [31:0] idx;
    err   = dec_err(b, addr);
    idx   = (addr - (b ? BASE1 : BASE0)) >> 2;
    e.err = err;
    e.cyc = (b ? W1 : W0) + 1;
    e.data = (!wr && !err) ? (b ? model1[idx[5:0]] : model0[idx[5:0]]) : 32'h0;
    sb.push_back(e);

    set_psel(b, 1'b1); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    check("setup_pready", rdy(b), 1'b0);
    @(posedge clk); #1;
    penable = 1'b1;

    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      cyc++;
      @(negedge clk);
      if (rdy(b)) seen = 1;
      else begin @(posedge clk); #1; end
    end
    e = sb.pop_front();
    check("pready_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("access_cycles", cyc, e.cyc);
      check("prdata", rdat(b), e.data);
      check("pslverr", 32'(serr(b)), 32'(e.err));
      if (wr && !err) begin
        if (b) model1[idx[5:0]] = wdata; else model0[idx[5:0]] = wdata;
      end
    end
    @(posedge clk); #1;
    penable = 1'b0;
    if (!hold) set_psel(b, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst = 1'b1; psel0 = 0; psel1 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    clear_models();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_pready0", pready0, 1'b0);
    check("rst_pslverr0", pslverr0, 1'b0);
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_proto0", proto_err0, 1'b0);
    check("rst_proto1", proto_err1, 1'b0);
    @(posedge clk); #1;

    // Basic write/read with two wait states.
    apb_xfer(0, 1, 32'h0001_F010, 32'hDEAD_BEEF, 0); idle();
    apb_xfer(0, 0, 32'h0001_F010, 32'h0, 0); idle();

    // Zero wait states, back-to-back writes then reads.
    for (int i = 0; i < 4; i++)
      apb_xfer(1, 1, BASE1 + 32'(i * 4), 32'hA5A5_0000 + 32'(i * 17), 1);
    for (int i = 0; i < 4; i++)
      apb_xfer(1, 0, BASE1 + 32'(i * 4), 32'h0, i != 3);
    idle();

    // Error responses leave memory intact.
    apb_xfer(0, 1, 32'h0001_F000, 32'h1111_2222, 0); idle();
    apb_xfer(0, 0, 32'h0001_F100, 32'h0, 0); idle();
    apb_xfer(0, 1, 32'h0001_F002, 32'h0BAD_0BAD, 0); idle();
    apb_xfer(0, 0, 32'h0001_E000, 32'h0, 0); idle();
    apb_xfer(0, 1, 32'h0001_F0FC, 32'h5555_AAAA, 0); idle();
    apb_xfer(0, 0, 32'h0001_F000, 32'h0, 0); idle();
    apb_xfer(0, 0, 32'h0001_F0FC, 32'h0, 0); idle();

    @(negedge clk);
    check("proto0_clean", proto_err0, 1'b0);
    @(posedge clk); #1;

    // penable without setup.
    psel0 = 1; penable = 1; pwrite = 0; paddr = 32'h0001_F000;
    @(negedge clk);
    check("nosetup_pready", pready0, 1'b0);
    @(posedge clk); #1;
    psel0 = 0; penable = 0;
    @(negedge clk);
    check("nosetup_proto", proto_err0, 1'b1);
    @(posedge clk); #1;
    apb_xfer(0, 0, 32'h0001_F010, 32'h0, 0); idle();
    @(negedge clk);
    check("proto_sticky", proto_err0, 1'b1);
    check("proto_other", proto_err1, 1'b0);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("proto_cleared", proto_err0, 1'b0);
    @(posedge clk); #1;

    // paddr changed during the wait phase.
    psel0 = 1; penable = 0; pwrite = 0; paddr = 32'h0001_F004;
    @(posedge clk); #1;
    penable = 1; paddr = 32'h0001_F008;
    @(posedge clk); #1;
    paddr = 32'h0001_F004;
    for (int i = 0; i < 10 && !pready0; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    psel0 = 0; penable = 0;
    @(negedge clk);
    check("addr_change_proto", proto_err0, 1'b1);
    @(posedge clk); #1;
    do_reset();

    // Reset during the wait phase of a write.
    apb_xfer(0, 1, 32'h0001_F020, 32'hCAFE_F00D, 0); idle();
    psel0 = 1; penable = 0; pwrite = 1; paddr = 32'h0001_F020; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    check("rstmid_wait_pready", pready0, 1'b0);
    @(posedge clk); #1;
    rst = 1; psel0 = 0; penable = 0;
    @(negedge clk);
    check("rstmid_pready", pready0, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    clear_models();
    @(negedge clk);
    check("postrst_pready", pready0, 1'b0);
    check("postrst_proto", proto_err0, 1'b0);
    @(posedge clk); #1;
    apb_xfer(0, 0, 32'h0001_F020, 32'h0, 0); idle();

    // INCR burst of four words, as issued by the bridge.
    start = rdy_cnt0;
    for (int i = 0; i < 4; i++)
      apb_xfer(0, 1, BASE0 + 32'(i * 4), 32'h0B00_0000 + 32'(i), i != 3);
    idle();
    check("burst_pready_pulses", rdy_cnt0 - start, 32'd4);
    for (int i = 0; i < 4; i++)
      apb_xfer(0, 0, BASE0 + 32'(i * 4), 32'h0, i != 3);
    idle();

    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
